// File: rtl/uart_rx_cfg_if.sv
// Bus bundle for the configurable UART receiver.
// The transmitting side uses the master modport and the receiver uses the slave modport.
// With UART_RX_PARITY_EN defined, the bundle also carries the parity-sense input i_Parity_Odd.
`timescale 1ns/1ps

interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_Rx_Serial;
`ifdef UART_RX_PARITY_EN
   logic                 i_Parity_Odd;
`endif
   logic                 o_Rx_DV;
   logic [DATA_BITS-1:0] o_Rx_Byte;
   logic                 o_Frame_Err;
   logic                 o_Parity_Err;
   logic                 o_Rx_Active;

`ifdef UART_RX_PARITY_EN
   modport master (
      output i_Rx_Serial, i_Parity_Odd,
      input  o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Rx_Active
   );

   modport slave (
      input  i_Rx_Serial, i_Parity_Odd,
      output o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Rx_Active
   );
`else
   modport master (
      output i_Rx_Serial,
      input  o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Rx_Active
   );

   modport slave (
      input  i_Rx_Serial,
      output o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Rx_Active
   );
`endif
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled by CLKS_PER_BIT clocks per bit.
// Frame format: start bit, DATA_BITS data bits (LSB first), and STOP_BITS stop bits.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data bits,
// together with the i_Parity_Odd input. Without the macro, o_Parity_Err is tied to 0.
// Reset is synchronous and active-low (i_Rst_L).
`timescale 1ns/1ps

module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input logic          i_Clock,
   input logic          i_Rst_L,
   uart_rx_cfg_if.slave rx_bus
);

   localparam int             TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]  LAST_TICK = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]  MID_TICK  = TW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY    = 3'd3,
`endif
      STOP      = 3'd4,
      CLEANUP   = 3'd5,
      WAIT_HIGH = 3'd6
   } state_t;

   state_t               state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic [TW-1:0]        timer;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 frame_err_acc;
   logic                 rx_dv;
   logic [DATA_BITS-1:0] rx_byte;
   logic                 frame_err;
   logic                 rx_active;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err_acc;
   logic                 parity_err;
`endif

   // Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_bus.i_Rx_Serial;
         rx_sync <= rx_meta;
      end
   end

   // Receive FSM: center on the start bit, then sample once per bit period; all outputs are registered.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         state         <= IDLE;
         timer         <= '0;
         bit_idx       <= '0;
         shift_reg     <= '0;
         frame_err_acc <= 1'b0;
         rx_dv         <= 1'b0;
         rx_byte       <= '0;
         frame_err     <= 1'b0;
         rx_active     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_acc <= 1'b0;
         parity_err     <= 1'b0;
`endif
      end else begin
         rx_dv <= 1'b0;
         case (state)
            IDLE: begin
               timer         <= '0;
               bit_idx       <= '0;
               frame_err_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
               parity_err_acc <= 1'b0;
`endif
               if (!rx_sync) begin
                  state <= START;
               end
            end

            START: begin
               if (timer == MID_TICK) begin
                  timer <= '0;
                  if (!rx_sync) begin
                     state     <= DATA;
                     rx_active <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            DATA: begin
               if (timer == LAST_TICK) begin
                  timer     <= '0;
                  shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                     state   <= PARITY;
`else
                     state   <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (timer == LAST_TICK) begin
                  timer          <= '0;
                  parity_err_acc <= ((^shift_reg) ^ rx_sync) != rx_bus.i_Parity_Odd;
                  state          <= STOP;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
`endif

            STOP: begin
               if (timer == LAST_TICK) begin
                  timer <= '0;
                  if (!rx_sync) begin
                     frame_err_acc <= 1'b1;
                  end
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     state   <= CLEANUP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            CLEANUP: begin
               rx_dv     <= 1'b1;
               rx_byte   <= shift_reg;
               frame_err <= frame_err_acc;
               rx_active <= 1'b0;
`ifdef UART_RX_PARITY_EN
               parity_err <= parity_err_acc;
`endif
               state <= rx_sync ? IDLE : WAIT_HIGH;
            end

            WAIT_HIGH: begin
               if (rx_sync) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign rx_bus.o_Rx_DV      = rx_dv;
   assign rx_bus.o_Rx_Byte    = rx_byte;
   assign rx_bus.o_Frame_Err  = frame_err;
   assign rx_bus.o_Rx_Active  = rx_active;
`ifdef UART_RX_PARITY_EN
   assign rx_bus.o_Parity_Err = parity_err;
`else
   assign rx_bus.o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg: 100 ns clock, 87 clocks per bit (8700 ns bit period).
// dut8 uses 8 data bits with 1 stop bit; dut7 uses 7 data bits with 2 stop bits.
`timescale 1ns/1ps

module tb_uart_rx_cfg;

   localparam int BIT_NS = 8700;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;

   int errors = 0;
   int checks = 0;
   int dv8    = 0;
   int dv7    = 0;

   logic [6:0] q7_byte[$];
   logic       q7_ferr[$];
   logic       q7_perr[$];

   uart_rx_cfg_if #(.DATA_BITS(8)) bus8();
   uart_rx_cfg_if #(.DATA_BITS(7)) bus7();

   uart_rx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(8), .STOP_BITS(1)) dut8 (
      .i_Clock (clk),
      .i_Rst_L (rst_l),
      .rx_bus  (bus8.slave)
   );

   uart_rx_cfg #(.CLKS_PER_BIT(87), .DATA_BITS(7), .STOP_BITS(2)) dut7 (
      .i_Clock (clk),
      .i_Rst_L (rst_l),
      .rx_bus  (bus7.slave)
   );

   // 100 ns clock
   always #50 clk = ~clk;

   // Count cycles with o_Rx_DV high and log every dut7 frame, sampling on the falling edge
   always @(negedge clk) begin
      if (bus8.o_Rx_DV) dv8++;
      if (bus7.o_Rx_DV) begin
         dv7++;
         q7_byte.push_back(bus7.o_Rx_Byte);
         q7_ferr.push_back(bus7.o_Frame_Err);
         q7_perr.push_back(bus7.o_Parity_Err);
      end
   end

   task automatic drive_line(input int which, input logic v);
      if (which == 7) bus7.i_Rx_Serial = v;
      else            bus8.i_Rx_Serial = v;
   endtask

   // Sends one frame; under parity builds a correct even parity bit is inserted.
   // The line is left at the last stop-bit level.
   task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                             input int nstop, input logic stop_val);
`ifdef UART_RX_PARITY_EN
      logic p;
      p = 1'b0;
`endif
      drive_line(which, 1'b0);
      #(BIT_NS);
      for (int i = 0; i < nbits; i++) begin
         drive_line(which, data[i]);
`ifdef UART_RX_PARITY_EN
         p = p ^ data[i];
`endif
         #(BIT_NS);
      end
`ifdef UART_RX_PARITY_EN
      drive_line(which, p);
      #(BIT_NS);
`endif
      for (int i = 0; i < nstop; i++) begin
         drive_line(which, stop_val);
         #(BIT_NS);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_p(input logic [7:0] data, input logic par_bit);
      drive_line(8, 1'b0);
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         drive_line(8, data[i]);
         #(BIT_NS);
      end
      drive_line(8, par_bit);
      #(BIT_NS);
      drive_line(8, 1'b1);
      #(BIT_NS);
   endtask
`endif

   task automatic test_reset();
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus8.o_Rx_DV !== 1'b0) begin errors++; $display("[TB] FAIL reset_dv: got %b expected 0", bus8.o_Rx_DV); end
      checks++; if (bus8.o_Rx_Byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte: got %h expected 00", bus8.o_Rx_Byte); end
      checks++; if (bus8.o_Frame_Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", bus8.o_Frame_Err); end
      checks++; if (bus8.o_Parity_Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", bus8.o_Parity_Err); end
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", bus8.o_Rx_Active); end
      checks++; if (bus7.o_Rx_Byte !== 7'h00) begin errors++; $display("[TB] FAIL reset_byte7: got %h expected 00", bus7.o_Rx_Byte); end
      rst_l = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (dv8 !== 0) begin errors++; $display("[TB] FAIL idle_no_dv: got %0d pulses expected 0", dv8); end
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL idle_active: got %b expected 0", bus8.o_Rx_Active); end
   endtask

   task automatic test_valid_frame();
      int start;
      start = dv8;
      @(negedge clk);
      fork
         send_frame(8, 9'h03F, 8, 1, 1'b1);
         begin
            #(5 * BIT_NS);
            checks++; if (bus8.o_Rx_Active !== 1'b1) begin errors++; $display("[TB] FAIL valid_active_mid: got %b expected 1", bus8.o_Rx_Active); end
         end
      join
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL valid_dv_count: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Rx_Byte !== 8'h3F) begin errors++; $display("[TB] FAIL valid_byte: got %h expected 3f", bus8.o_Rx_Byte); end
      checks++; if (bus8.o_Frame_Err !== 1'b0) begin errors++; $display("[TB] FAIL valid_ferr: got %b expected 0", bus8.o_Frame_Err); end
      checks++; if (bus8.o_Parity_Err !== 1'b0) begin errors++; $display("[TB] FAIL valid_perr: got %b expected 0", bus8.o_Parity_Err); end
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL valid_active_after: got %b expected 0", bus8.o_Rx_Active); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_glitch();
      int start;
      start = dv8;
      @(negedge clk);
      drive_line(8, 1'b0);
      #300;
      drive_line(8, 1'b1);
      repeat (60) @(negedge clk);
      checks++; if (dv8 - start !== 0) begin errors++; $display("[TB] FAIL glitch_dv: got %0d expected 0", dv8 - start); end
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL glitch_active: got %b expected 0", bus8.o_Rx_Active); end
      checks++; if (bus8.o_Rx_Byte !== 8'h3F) begin errors++; $display("[TB] FAIL glitch_byte_hold: got %h expected 3f", bus8.o_Rx_Byte); end
      start = dv8;
      @(negedge clk);
      send_frame(8, 9'h081, 8, 1, 1'b1);
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL glitch_recover_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Rx_Byte !== 8'h81) begin errors++; $display("[TB] FAIL glitch_recover_byte: got %h expected 81", bus8.o_Rx_Byte); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_frame_error();
      int start;
      start = dv8;
      @(negedge clk);
      send_frame(8, 9'h055, 8, 1, 1'b0);
      #(3 * BIT_NS);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL ferr_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Frame_Err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b expected 1", bus8.o_Frame_Err); end
      checks++; if (bus8.o_Rx_Byte !== 8'h55) begin errors++; $display("[TB] FAIL ferr_byte: got %h expected 55", bus8.o_Rx_Byte); end
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL ferr_active: got %b expected 0", bus8.o_Rx_Active); end
      drive_line(8, 1'b1);
      #(2 * BIT_NS);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL break_single_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Frame_Err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_hold: got %b expected 1", bus8.o_Frame_Err); end
      start = dv8;
      @(negedge clk);
      send_frame(8, 9'h00F, 8, 1, 1'b1);
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL ferr_next_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Frame_Err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clear: got %b expected 0", bus8.o_Frame_Err); end
      checks++; if (bus8.o_Rx_Byte !== 8'h0F) begin errors++; $display("[TB] FAIL ferr_next_byte: got %h expected 0f", bus8.o_Rx_Byte); end
      repeat (20) @(negedge clk);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int start;
      start = dv8;
      @(negedge clk);
      send_frame_p(8'hA5, 1'b1);
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL par_bad_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Parity_Err !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_flag: got %b expected 1", bus8.o_Parity_Err); end
      start = dv8;
      @(negedge clk);
      send_frame_p(8'hA5, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL par_good_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Parity_Err !== 1'b0) begin errors++; $display("[TB] FAIL par_good_flag: got %b expected 0", bus8.o_Parity_Err); end
      checks++; if (bus8.o_Rx_Byte !== 8'hA5) begin errors++; $display("[TB] FAIL par_good_byte: got %h expected a5", bus8.o_Rx_Byte); end
      repeat (20) @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid_frame();
      int start;
      logic [7:0] c3;
      c3 = 8'hC3;
      start = dv8;
      @(negedge clk);
      drive_line(8, 1'b0);
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         drive_line(8, c3[i]);
         #(BIT_NS);
      end
      drive_line(8, c3[4]);
      #4300;
      checks++; if (bus8.o_Rx_Active !== 1'b1) begin errors++; $display("[TB] FAIL midrst_active_before: got %b expected 1", bus8.o_Rx_Active); end
      rst_l = 1'b0;
      #100;
      rst_l = 1'b1;
      checks++; if (bus8.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL midrst_active: got %b expected 0", bus8.o_Rx_Active); end
      checks++; if (bus8.o_Rx_Byte !== 8'h00) begin errors++; $display("[TB] FAIL midrst_byte: got %h expected 00", bus8.o_Rx_Byte); end
      checks++; if (bus8.o_Rx_DV !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dv: got %b expected 0", bus8.o_Rx_DV); end
      checks++; if (bus8.o_Frame_Err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ferr: got %b expected 0", bus8.o_Frame_Err); end
      checks++; if (bus8.o_Parity_Err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_perr: got %b expected 0", bus8.o_Parity_Err); end
      drive_line(8, 1'b1);
      #(2 * BIT_NS);
      checks++; if (dv8 - start !== 0) begin errors++; $display("[TB] FAIL midrst_discard: got %0d expected 0", dv8 - start); end
      @(negedge clk);
      send_frame(8, 9'h0C3, 8, 1, 1'b1);
      repeat (2) @(negedge clk);
      checks++; if (dv8 - start !== 1) begin errors++; $display("[TB] FAIL midrst_next_dv: got %0d expected 1", dv8 - start); end
      checks++; if (bus8.o_Rx_Byte !== 8'hC3) begin errors++; $display("[TB] FAIL midrst_next_byte: got %h expected c3", bus8.o_Rx_Byte); end
      checks++; if (bus8.o_Frame_Err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_next_ferr: got %b expected 0", bus8.o_Frame_Err); end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int start;
      start = dv7;
      q7_byte.delete();
      q7_ferr.delete();
      q7_perr.delete();
      @(negedge clk);
      send_frame(7, 9'h05A, 7, 2, 1'b1);
      send_frame(7, 9'h05A, 7, 2, 1'b1);
      repeat (5) @(negedge clk);
      checks++; if (dv7 - start !== 2) begin errors++; $display("[TB] FAIL b2b_dv_count: got %0d expected 2", dv7 - start); end
      for (int i = 0; i < q7_byte.size(); i++) begin
         checks++; if (q7_byte[i] !== 7'h5A) begin errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected 5a", i, q7_byte[i]); end
         checks++; if (q7_ferr[i] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ferr%0d: got %b expected 0", i, q7_ferr[i]); end
         checks++; if (q7_perr[i] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_perr%0d: got %b expected 0", i, q7_perr[i]); end
      end
      checks++; if (bus7.o_Rx_Active !== 1'b0) begin errors++; $display("[TB] FAIL b2b_active: got %b expected 0", bus7.o_Rx_Active); end
   endtask

   // Run all scenarios in order, then print the summary
   initial begin
      bus8.i_Rx_Serial = 1'b1;
      bus7.i_Rx_Serial = 1'b1;
`ifdef UART_RX_PARITY_EN
      bus8.i_Parity_Odd = 1'b0;
      bus7.i_Parity_Odd = 1'b0;
`endif
      $display("[TB] uart_rx_cfg directed test start");
      test_reset();
      test_valid_frame();
      test_glitch();
      test_frame_error();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per bit period (legal range 4..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal values 1 or 2).
REQ-004 The block SHALL have port i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_Rst_L  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port i_Rx_Serial  input  1  asynchronous serial line; idle level is 1.
REQ-007 The block SHALL have port i_Parity_Odd  input  1  parity sense (1 = odd, 0 = even); present only under UART_RX_PARITY_EN.
REQ-008 The block SHALL have port o_Rx_DV  output  1  one-cycle pulse marking a completed frame.
REQ-009 The block SHALL have port o_Rx_Byte  output  DATA_BITS  received data, LSB first on the line.
REQ-010 The block SHALL have port o_Frame_Err  output  1  a stop bit was sampled as 0 in the last frame.
REQ-011 The block SHALL have port o_Parity_Err  output  1  parity mismatch in the last frame.
REQ-012 The block SHALL have port o_Rx_Active  output  1  high from start-bit confirmation until o_Rx_DV.

Function
REQ-013 The block SHALL pass i_Rx_Serial through a 2-flop synchronizer whose flops reset to 1; all FSM decisions SHALL use the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
REQ-015 In IDLE, a synchronized 0 SHALL move the FSM to START and clear the bit-timer.
REQ-016 In START, after (CLKS_PER_BIT-1)/2 cycles, a 0 SHALL confirm the start bit (go to DATA, assert o_Rx_Active); a 1 SHALL be treated as a glitch (return to IDLE, no o_Rx_DV).
REQ-017 DATA SHALL sample each bit CLKS_PER_BIT cycles after the previous sample, shifting LSB first into o_Rx_Byte position 0..DATA_BITS-1; after DATA_BITS samples the FSM SHALL go to PARITY if enabled, else STOP.
REQ-018 STOP SHALL sample STOP_BITS stop bits at mid-bit; any 0 sample SHALL set the frame-error result.
REQ-019 CLEANUP SHALL last exactly one cycle, pulse o_Rx_DV, update o_Rx_Byte, o_Frame_Err and o_Parity_Err together, and deassert o_Rx_Active.
REQ-020 o_Rx_DV SHALL rise exactly one cycle after the final stop-bit sample.
REQ-021 o_Rx_Byte and the error flags SHALL hold their values until the next o_Rx_DV.
REQ-022 After CLEANUP the FSM SHALL go to IDLE if the line is 1, else to WAIT_HIGH; WAIT_HIGH SHALL stay until the line is 1, so a break condition yields exactly one frame.
REQ-023 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1 without overflow.

Reset
REQ-024 With i_Rst_L = 0 at a clock edge, the FSM SHALL go to IDLE, the synchronizer SHALL go to 1, and the timer and bit index SHALL go to 0.
REQ-025 Reset SHALL force o_Rx_DV = 0, o_Rx_Byte = 0, o_Frame_Err = 0, o_Parity_Err = 0 and o_Rx_Active = 0, including mid-frame; the partial frame SHALL be discarded.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, the frame SHALL include one parity bit after the data bits, and the PARITY state SHALL set o_Parity_Err when XOR(data, parity bit) differs from i_Parity_Odd.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state and i_Parity_Odd SHALL be absent, and o_Parity_Err SHALL be tied to 0.

Verification
All scenarios use a 100 ns clock, CLKS_PER_BIT = 87 and an 8700 ns bit period.
REQ-028 Send 8'h3F with a valid frame -> one o_Rx_DV pulse, o_Rx_Byte = 8'h3F, both error flags = 0, o_Rx_Active low afterwards.
REQ-029 Drive a 300 ns low glitch on an idle line -> no o_Rx_DV, FSM back in IDLE, o_Rx_Active = 0 after 44 cycles.
REQ-030 Send 8'h55 with stop bit = 0, then hold the line low for 3 bit periods -> one o_Rx_DV with o_Frame_Err = 1 and o_Rx_Byte = 8'h55; no further o_Rx_DV until the line returns high.
REQ-031 With UART_RX_PARITY_EN defined and i_Parity_Odd = 0, send 8'hA5 with parity bit 1 -> o_Parity_Err = 1; then send 8'hA5 with parity bit 0 -> o_Parity_Err = 0.
REQ-032 Pulse i_Rst_L low during data bit 4 of a frame -> all outputs 0 the next cycle; a following frame 8'hC3 is received correctly.
REQ-033 With DATA_BITS = 7 and STOP_BITS = 2, send 7'h5A twice back-to-back -> two o_Rx_DV pulses, both with 7'h5A and no errors.
